// File: rtl/laa_responder.sv
// LAA accelerator responder: 31-entry register file, status register r31 and
// an iterative shift-add unsigned multiplier retiring BITS_PER_CYCLE bits per cycle.
module laa_responder #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [1:0]        opcode,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int L  = DATA_W / BITS_PER_CYCLE;
  localparam int IW = $clog2(L + 1);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       regs_q [0:30];
  logic [DATA_W-1:0]       regs_d [0:30];
  logic [2*DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]       mplier_q, mplier_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [2*DATA_W-1:0]     partial;
  logic [IW-1:0]           iter_q, iter_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    last;

  assign last = (state_q == RUN) && (iter_q == IW'(L - 1));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (opcode == OP_MUL) state_d = RUN;
      RUN:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // Register-file access and the multiply step; the commit is applied last so
  // it overrides any same-edge write to r2/r3 (those are already flagged busy).
  always_comb begin
    regs_d   = regs_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    done_d   = done_q;
    err_d    = err_q;
    dout_d   = dout_q;
    partial  = '0;

    case (opcode)
      OP_READ: begin
        if (addr == 5'd31) dout_d = {{(DATA_W-2){1'b0}}, err_q, done_q};
        else               dout_d = regs_q[addr];
      end
      OP_WRITE: begin
        if (addr == 5'd31) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end else if ((state_q == RUN) && (addr < 5'd4)) begin
          err_d = 1'b1;
        end else begin
          regs_d[addr] = data_in;
        end
      end
      OP_MUL: begin
        if (state_q == RUN) begin
          err_d = 1'b1;
        end else begin
          mcand_d  = {{DATA_W{1'b0}}, regs_q[0]};
          mplier_d = regs_q[1];
          acc_d    = '0;
          iter_d   = '0;
          done_d   = 1'b0;
        end
      end
      default: ;
    endcase

    if (state_q == RUN) begin
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
        if (mplier_q[j]) partial = partial + (mcand_q << j);
      end
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      iter_d   = iter_q + 1'b1;
      if (last) begin
        regs_d[2] = acc_d[DATA_W-1:0];
        regs_d[3] = acc_d[2*DATA_W-1:DATA_W];
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      for (int i = 0; i < 31; i++) regs_q[i] <= regs_d[i];
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_laa_responder.sv
// Self-checking bench for laa_responder: a per-cycle reference model plus
// directed scenarios; a second instance with BITS_PER_CYCLE=4 shares the stimulus.
module tb_laa_responder;

  logic        clk = 1'b0;
  logic        Rst;
  logic [1:0]  opcode;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out, data_out4;
  logic        busy, busy4;

  int checkCnt = 0;
  int passCnt  = 0;

  laa_responder #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .Rst(Rst), .opcode(opcode), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy));

  laa_responder #(.DATA_W(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .Rst(Rst), .opcode(opcode), .addr(addr),
    .data_in(data_in), .data_out(data_out4), .busy(busy4));

  always #5 clk = ~clk;

  // Reference model: product computed directly, completion after 32 cycles.
  logic [31:0] mregs [0:30];
  logic [63:0] mprod;
  logic [31:0] mdout;
  logic        mdone, merr, mbusy, wasBusy;
  int          mcnt;

  always @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 31; i++) mregs[i] = 32'd0;
      mdone = 1'b0; merr = 1'b0; mbusy = 1'b0; mcnt = 0; mdout = 32'd0; mprod = 64'd0;
    end else begin
      wasBusy = mbusy;
      case (opcode)
        2'd1: mdout = (addr == 5'd31) ? {30'd0, merr, mdone} : mregs[addr];
        2'd2: begin
          if (addr == 5'd31) begin mdone = 1'b0; merr = 1'b0; end
          else if (wasBusy && addr < 5'd4) merr = 1'b1;
          else mregs[addr] = data_in;
        end
        2'd3: begin
          if (wasBusy) merr = 1'b1;
          else begin
            mprod = {32'd0, mregs[0]} * {32'd0, mregs[1]};
            mbusy = 1'b1; mdone = 1'b0; mcnt = 32;
          end
        end
        default: ;
      endcase
      if (wasBusy) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          mregs[2] = mprod[31:0];
          mregs[3] = mprod[63:32];
          mdone = 1'b1;
          mbusy = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput("cyc_data_out", {32'd0, data_out}, {32'd0, mdout});
    checkOutput("cyc_busy", {63'd0, busy}, {63'd0, mbusy});
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    opcode = op; addr = a; data_in = d;
  endtask

  task automatic readReg(input logic [4:0] a, input logic [31:0] exp, input string name);
    applyStimulus(2'd1, a, 32'd0);
    applyStimulus(2'd0, 5'd0, 32'd0);
    checkOutput(name, {32'd0, data_out}, {32'd0, exp});
  endtask

  task automatic waitDone();
    int n = 0;
    do begin
      applyStimulus(2'd0, 5'd0, 32'd0);
      n++;
    end while (busy && n < 200);
    checkOutput("wait_done_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int busyCnt;
    Rst = 1'b0; opcode = 2'd0; addr = 5'd0; data_in = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_data_out", {32'd0, data_out}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    Rst = 1'b1;
    readReg(5'd31, 32'd0, "reset_r31");

    // Basic multiply with r31 polled every cycle
    applyStimulus(2'd2, 5'd0, 32'd7);
    applyStimulus(2'd2, 5'd1, 32'd6);
    applyStimulus(2'd3, 5'd0, 32'd0);
    busyCnt = 0;
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(2'd1, 5'd31, 32'd0);
      if (busy) busyCnt++;
      if (k >= 2) checkOutput($sformatf("poll_r31_N+%0d", k - 1), {32'd0, data_out},
                              (k - 1 == 33) ? 64'd1 : 64'd0);
    end
    applyStimulus(2'd0, 5'd0, 32'd0);
    checkOutput("busy_cycles", busyCnt, 64'd32);
    readReg(5'd2, 32'd42, "basic_r2");
    readReg(5'd3, 32'd0, "basic_r3");
    checkOutput("model_pin_r2", {32'd0, mregs[2]}, 64'd42);

    // Commit-edge collision
    applyStimulus(2'd2, 5'd0, 32'd10);
    applyStimulus(2'd2, 5'd1, 32'd10);
    applyStimulus(2'd3, 5'd0, 32'd0);
    for (int i = 1; i <= 31; i++) applyStimulus(2'd0, 5'd0, 32'd0);
    applyStimulus(2'd1, 5'd2, 32'd0);
    applyStimulus(2'd1, 5'd2, 32'd0);
    checkOutput("commit_edge_old_r2", {32'd0, data_out}, 64'd42);
    applyStimulus(2'd0, 5'd0, 32'd0);
    checkOutput("commit_edge_new_r2", {32'd0, data_out}, 64'd100);

    // Maximum operands
    applyStimulus(2'd2, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(2'd2, 5'd1, 32'hFFFF_FFFF);
    applyStimulus(2'd3, 5'd0, 32'd0);
    waitDone();
    readReg(5'd2, 32'h0000_0001, "max_r2");
    readReg(5'd3, 32'hFFFF_FFFE, "max_r3");
    checkOutput("model_pin_r3", {32'd0, mregs[3]}, 64'hFFFF_FFFE);

    // Busy hazards
    applyStimulus(2'd2, 5'd0, 32'd3);
    applyStimulus(2'd2, 5'd1, 32'd5);
    applyStimulus(2'd3, 5'd0, 32'd0);
    for (int i = 1; i <= 3; i++) applyStimulus(2'd0, 5'd0, 32'd0);
    applyStimulus(2'd2, 5'd0, 32'd9);
    applyStimulus(2'd3, 5'd0, 32'd0);
    applyStimulus(2'd2, 5'd10, 32'h0000_ABCD);
    waitDone();
    readReg(5'd2, 32'd15, "hazard_r2");
    readReg(5'd0, 32'd3, "hazard_r0");
    readReg(5'd10, 32'h0000_ABCD, "hazard_r10");
    readReg(5'd31, 32'd3, "hazard_r31");
    applyStimulus(2'd2, 5'd31, 32'h1234_5678);
    readReg(5'd31, 32'd0, "hazard_r31_cleared");

    // Reset mid-operation
    readReg(5'd10, 32'h0000_ABCD, "pre_reset_r10");
    applyStimulus(2'd2, 5'd0, 32'h0000_1234);
    applyStimulus(2'd2, 5'd1, 32'h0000_0010);
    applyStimulus(2'd3, 5'd0, 32'd0);
    for (int i = 1; i <= 10; i++) applyStimulus(2'd0, 5'd0, 32'd0);
    @(posedge clk);
    #3;
    checkOutput("busy_before_reset", {63'd0, busy}, 64'd1);
    Rst = 1'b0;
    #1;
    checkOutput("reset_async_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_async_data_out", {32'd0, data_out}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    Rst = 1'b1;
    readReg(5'd0, 32'd0, "post_reset_r0");
    readReg(5'd1, 32'd0, "post_reset_r1");
    readReg(5'd2, 32'd0, "post_reset_r2");
    readReg(5'd3, 32'd0, "post_reset_r3");
    readReg(5'd31, 32'd0, "post_reset_r31");

    // Four bits per cycle on the second instance
    applyStimulus(2'd2, 5'd0, 32'h0001_0000);
    applyStimulus(2'd2, 5'd1, 32'h0001_0000);
    applyStimulus(2'd3, 5'd0, 32'd0);
    busyCnt = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'd1, 5'd31, 32'd0);
      if (busy4) busyCnt++;
      if (k >= 2) checkOutput($sformatf("bpc4_r31_N+%0d", k - 1), {32'd0, data_out4},
                              (k - 1 >= 9) ? 64'd1 : 64'd0);
    end
    checkOutput("bpc4_busy_cycles", busyCnt, 64'd8);
    waitDone();
    readReg(5'd2, 32'd0, "sweep_r2");
    checkOutput("bpc4_r2", {32'd0, data_out4}, 64'd0);
    readReg(5'd3, 32'd1, "sweep_r3");
    checkOutput("bpc4_r3", {32'd0, data_out4}, 64'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/laa_responder.md
Name: laa_responder

Overview:
- Responder (accelerator) side of the LAA custom-instruction protocol.
- The core-side decoder drives `opcode`/`addr`/`data_in` every cycle. This block holds the LAA register file, runs a multi-cycle unsigned multiply, and returns `data_out`.
- Completion is signalled through read-only status register 31. The core polls it: the value is zero while busy and non-zero when finished.

Parameters:
- DATA_W, 32, width of LAA registers and operands.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Must divide DATA_W; legal values are 1, 2, 4.

Ports:
- clk  input  1  single clock, rising edge.
- Rst  input  1  reset, asynchronous, active-low (0 = reset).
- opcode  input  2  0=NONE, 1=READ, 2=WRITE, 3=MULTIPLY; sampled every rising edge.
- addr  input  5  LAA register index for READ/WRITE.
- data_in  input  DATA_W  write data for WRITE.
- data_out  output  DATA_W  registered read data.
- busy  output  1  high while a multiply is in progress.

Behaviour:
- Register map:
  - r0 = multiplicand A, r1 = multiplier B.
  - r2 = product low word, r3 = product high word.
  - r4..r30 = general scratch.
  - r31 = status {DATA_W-2 zeros, err, done}.
- Reset (Rst=0, asynchronous):
  - r0..r30, data_out, busy, done, err and the FSM all go to 0.
  - An in-flight multiply is discarded without committing.
- FSM states: IDLE, RUN.
- IDLE, opcode=MULTIPLY at edge N:
  - latch r0/r1 into internal operand registers;
  - clear the 2*DATA_W accumulator; iter=0;
  - busy=1, done=0; go to RUN.
- RUN, each edge:
  - shift-add BITS_PER_CYCLE bits of B into the accumulator; iter++.
  - At edge N+L, where L = DATA_W/BITS_PER_CYCLE (32 by default), the full product is committed: r2 = low, r3 = high, done=1, busy=0, return to IDLE.
- READ at edge E: data_out <= value of reg[addr] before edge E (one-cycle latency).
  - r31 reads {err, done}.
  - data_out holds its previous value on NONE/WRITE/MULTIPLY cycles.
- WRITE at edge E:
  - reg[addr] <= data_in.
  - WRITE to r31 does not store data; it clears done and err.
  - While busy, WRITE to r0..r3 is dropped and sets err=1 (sticky). Writes to r4..r30 proceed normally.
- MULTIPLY while busy: ignored, sets err=1, does not restart the multiply.
- Operands are latched at start, so later writes to r0/r1 cannot affect the running product.
- Simultaneous events at the commit edge N+L:
  - READ of r2/r3/r31 returns the pre-commit values (r31 reads 0).
  - A WRITE to r2/r3 on that edge is dropped (err=1); the commit wins.
- Arithmetic: unsigned, full 2*DATA_W product, no overflow possible.
- Result timing: data_out shows the new r31=1 at edge N+L+1 at the earliest (READ of r31 issued at that edge).
- Reset mid-RUN: immediate abort; r2/r3 read 0 afterwards.
- addr is ignored for NONE and MULTIPLY.

Test Plan:
- Basic multiply, latency and r3:
  - Stimulus: after reset, WRITE r0=7, r1=6; MULTIPLY at edge N; READ r31 every cycle.
  - Required: data_out=0 until the read sampled at edge N+33, which returns 1; READ r2 -> 42; READ r3 -> 0; busy high for exactly 32 cycles.
- Maximum operands:
  - Stimulus: r0=0xFFFFFFFF, r1=0xFFFFFFFF, MULTIPLY, wait done.
  - Required: r2=0x00000001, r3=0xFFFFFFFE.
- Busy hazards:
  - Stimulus: start 3*5; at edge N+4 WRITE r0=9 and issue MULTIPLY again; WRITE r10=0xABCD.
  - Required: r2=15 at done; r0 still reads 3; r10 reads 0xABCD; r31 reads 0x3; then WRITE r31 (any data) makes r31 read 0x0.
- Commit-edge collision:
  - Stimulus: READ r2 sampled at edge N+32 with a prior result of 42 and a new product of 100 (10*10).
  - Required: that read returns 42; the read at N+33 returns 100.
- Reset mid-operation:
  - Stimulus: r0=0x1234, r1=0x10, MULTIPLY; assert Rst=0 at N+10 for 2 cycles, asynchronous to clk.
  - Required: busy and data_out drop to 0 immediately; after release, r0..r3 and r31 all read 0.
- Parameter sweep:
  - Stimulus: BITS_PER_CYCLE=4 with 0x10000*0x10000.
  - Required: done after 8 cycles; r2=0, r3=1.
